// File: rtl/avsdpll_ctrl.sv
// avsdpll_ctrl -- power-up, configuration and lock-monitor sequencer for the
// avsdpll_1v8 analog PLL macro.
//
// Brings the macro up in order: charge pump first, then the VCO. It then
// qualifies lock by counting divided feedback ticks over a fixed window and
// comparing the count with a software-supplied expected value. Once locked,
// it keeps re-measuring in back-to-back windows.
//
// Ports
//   wb_clk_i, wb_rst_i   clock; synchronous active-high reset
//   cfg_valid/cfg_ready  config handshake (ready only in OFF, LOCKED, FAULT)
//   cfg_en               1 = bring up / retune, 0 = power down
//   cfg_b, cfg_exp       divider select and expected ticks per window
//   fb_tick              one-cycle feedback pulse, already in wb_clk_i domain
//   pll_enb_cp/_vco      active-low macro enables
//   pll_b                divider select to the macro
//   pll_locked/pll_fault lock status
//   meas_count           tick count of the last completed window
//   state_o              current state, for debug
module avsdpll_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned CP_DLY     = 16,
  parameter int unsigned SETTLE_CYC = 1024,
  parameter int unsigned WIN_CYC    = 256,
  parameter int unsigned TOL        = 2,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [3:0]       cfg_b,
  input  logic [CNT_W-1:0] cfg_exp,
  input  logic             fb_tick,
  output logic             pll_enb_cp,
  output logic             pll_enb_vco,
  output logic [3:0]       pll_b,
  output logic             pll_locked,
  output logic             pll_fault,
  output logic [CNT_W-1:0] meas_count,
  output logic [2:0]       state_o
);

  localparam int unsigned T_MAX =
    (CP_DLY > SETTLE_CYC) ? ((CP_DLY > WIN_CYC) ? CP_DLY : WIN_CYC)
                          : ((SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC);
  localparam int unsigned TMR_W = (T_MAX > 2) ? $clog2(T_MAX) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned DW    = CNT_W + 1;

  localparam logic [TMR_W-1:0] CP_LAST  = TMR_W'(CP_DLY - 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WIN_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    EN_CP   = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    LOCKED  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] meas_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [3:0]       b_d;
  logic             enb_cp_d, enb_vco_d, locked_d, fault_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_fin;
  logic [CNT_W:0]   diff;
  logic             pass;

  assign cfg_ready = (state_q == OFF) || (state_q == LOCKED) || (state_q == FAULT);
  assign accept    = cfg_valid && cfg_ready;
  assign state_o   = state_q;

  // Window count including the current cycle's tick, saturating at all-ones.
  always_comb begin
    cnt_fin = (fb_tick && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
    diff    = (cnt_fin >= exp_q) ? ({1'b0, cnt_fin} - {1'b0, exp_q})
                                 : ({1'b0, exp_q} - {1'b0, cnt_fin});
    pass    = (diff <= DW'(TOL));
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    meas_d  = meas_count;
    retry_d = retry_q;
    exp_d   = exp_q;
    b_d     = pll_b;

    unique case (state_q)
      OFF, FAULT: ;
      EN_CP: begin
        if (timer_q == CP_LAST) begin
          state_d = SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SETTLE: begin
        if (timer_q == SET_LAST) begin
          state_d = MEASURE;
          timer_d = '0;
          count_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      MEASURE, LOCKED: begin
        count_d = cnt_fin;
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == WIN_LAST) begin
          meas_d  = cnt_fin;
          timer_d = '0;
          count_d = '0;
          if (pass) begin
            state_d = LOCKED;
            retry_d = '0;
          end else if (state_q == LOCKED) begin
            state_d = SETTLE;
            retry_d = '0;
          end else if (retry_q == RTY_MAX) begin
            state_d = FAULT;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = SETTLE;
          end
        end
      end
      default: state_d = OFF;
    endcase

    // A config accept overrides the sequencer, including a coincident window end
    // (meas_count still records that completed window).
    if (accept) begin
      timer_d = '0;
      count_d = '0;
      retry_d = '0;
      if (cfg_en) begin
        b_d     = cfg_b;
        exp_d   = cfg_exp;
        state_d = (state_q == LOCKED) ? SETTLE : EN_CP;
      end else begin
        state_d = OFF;
      end
    end

    enb_cp_d  = !((state_d == EN_CP) || (state_d == SETTLE) ||
                  (state_d == MEASURE) || (state_d == LOCKED));
    enb_vco_d = !((state_d == SETTLE) || (state_d == MEASURE) || (state_d == LOCKED));
    locked_d  = (state_d == LOCKED);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= OFF;
      timer_q     <= '0;
      count_q     <= '0;
      meas_count  <= '0;
      retry_q     <= '0;
      exp_q       <= '0;
      pll_b       <= '0;
      pll_enb_cp  <= 1'b1;
      pll_enb_vco <= 1'b1;
      pll_locked  <= 1'b0;
      pll_fault   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      meas_count  <= meas_d;
      retry_q     <= retry_d;
      exp_q       <= exp_d;
      pll_b       <= b_d;
      pll_enb_cp  <= enb_cp_d;
      pll_enb_vco <= enb_vco_d;
      pll_locked  <= locked_d;
      pll_fault   <= fault_d;
    end
  end

endmodule

// File: tb/tb_avsdpll_ctrl.sv
// Testbench for avsdpll_ctrl. Directed sequence with randomized tick phases,
// divider values, expected counts and tick drop-outs. Expected window counts
// and pass/fail come from a record of every tick the bench drove.
module tb_avsdpll_ctrl;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CP    = 4;
  localparam int unsigned ST    = 8;
  localparam int unsigned WIN   = 16;
  localparam int unsigned TOL   = 1;
  localparam int unsigned MR    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             cfg_en = 1'b0;
  logic [3:0]       cfg_b = '0;
  logic [CNT_W-1:0] cfg_exp = '0;
  logic             fb_tick = 1'b0;
  logic             pll_enb_cp, pll_enb_vco, pll_locked, pll_fault;
  logic [3:0]       pll_b;
  logic [CNT_W-1:0] meas_count;
  logic [2:0]       state_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_mode = 0;   // 0 = no ticks, otherwise tick period
  int phase = 0;
  int drop_pct = 0;    // chance of suppressing an individual tick
  bit hist [0:8191];   // hist[k] = fb_tick value sampled at edge k

  always #5 clk = ~clk;

  avsdpll_ctrl #(
    .CNT_W(CNT_W), .CP_DLY(CP), .SETTLE_CYC(ST), .WIN_CYC(WIN), .TOL(TOL), .MAX_RETRY(MR)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_en(cfg_en),
    .cfg_b(cfg_b), .cfg_exp(cfg_exp), .fb_tick(fb_tick),
    .pll_enb_cp(pll_enb_cp), .pll_enb_vco(pll_enb_vco), .pll_b(pll_b),
    .pll_locked(pll_locked), .pll_fault(pll_fault),
    .meas_count(meas_count), .state_o(state_o)
  );

  function automatic bit gen(int k);
    if (tick_mode == 0) return 1'b0;
    if (drop_pct > 0 && int'($urandom_range(0, 99)) < drop_pct) return 1'b0;
    return ((k + phase) % tick_mode) == 0;
  endfunction

  // Ticks the DUT sees in the WIN edges ending at edge e.
  function automatic int win_sum(int e);
    int s = 0;
    for (int k = e - int'(WIN) + 1; k <= e; k++) s += int'(hist[k]);
    return s;
  endfunction

  function automatic bit passes(int s, int e);
    int d = (s > e) ? s - e : e - s;
    return d <= int'(TOL);
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    fb_tick = gen(cyc + 1);
    hist[cyc + 1] = fb_tick;
  endtask

  task automatic run_to(int e);
    while (cyc < e) step();
  endtask

  task automatic set_mode(int m, int ph, int dp);
    tick_mode = m;
    phase = ph;
    drop_pct = dp;
    fb_tick = gen(cyc + 1);
    hist[cyc + 1] = fb_tick;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Present a config for one cycle; returns the last edge before the sampling edge.
  task automatic accept(bit en, logic [3:0] b, logic [CNT_W-1:0] e, output int n);
    n = cyc;
    cfg_valid = 1'b1;
    cfg_en = en;
    cfg_b = b;
    cfg_exp = e;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, e, s, exp2;
    logic [3:0] rb;

    // 1. reset
    step(); step(); step();
    chk("rst_enb_cp", pll_enb_cp, 1);
    chk("rst_enb_vco", pll_enb_vco, 1);
    chk("rst_b", pll_b, 0);
    chk("rst_locked", pll_locked, 0);
    chk("rst_fault", pll_fault, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_state", state_o, 0);
    chk("rst_meas", meas_count, 0);
    rst = 1'b0;

    // 2. bring-up from OFF, tick every 2nd cycle
    set_mode(2, int'($urandom_range(0, 1)), 0);
    exp2 = 7 + int'($urandom_range(0, 2));
    accept(1'b1, 4'hA, CNT_W'(exp2), n);
    chk("up_b", pll_b, 4'hA);
    chk("up_enb_cp", pll_enb_cp, 0);
    chk("up_enb_vco_early", pll_enb_vco, 1);
    chk("up_state_encp", state_o, 1);
    chk("up_ready_busy", cfg_ready, 0);
    run_to(n + 4);
    chk("up_enb_vco_n4", pll_enb_vco, 1);
    run_to(n + 5);
    chk("up_enb_vco_n5", pll_enb_vco, 0);
    chk("up_state_settle", state_o, 2);
    run_to(n + 13);
    chk("up_state_measure", state_o, 3);
    run_to(n + 28);
    chk("up_locked_early", pll_locked, 0);
    run_to(n + 29);
    s = win_sum(cyc);
    chk("up_meas", meas_count, s);
    chk("up_locked", pll_locked, passes(s, exp2));
    chk("up_state_locked", state_o, 4);
    chk("up_ready_locked", cfg_ready, 1);
    e = cyc;

    // 4. tick rate drops while locked
    set_mode(4, int'($urandom_range(0, 3)), 0);
    e += int'(WIN);
    run_to(e - 1);
    chk("drop_locked_hold", pll_locked, 1);
    run_to(e);
    s = win_sum(e);
    chk("drop_meas", meas_count, s);
    chk("drop_locked", pll_locked, passes(s, exp2));
    chk("drop_state", state_o, 2);
    chk("drop_enb_vco", pll_enb_vco, 0);
    set_mode(2, int'($urandom_range(0, 1)), 0);

    // 5a. config ignored during SETTLE
    step(); step();
    chk("settle_ready", cfg_ready, 0);
    accept(1'b0, 4'h5, CNT_W'(3), n);
    chk("settle_ign_state", state_o, 2);
    chk("settle_ign_b", pll_b, 4'hA);
    chk("settle_ign_enb_cp", pll_enb_cp, 0);

    e += int'(ST + WIN);
    run_to(e - 1);
    chk("relock_early", pll_locked, 0);
    run_to(e);
    s = win_sum(e);
    chk("relock_meas", meas_count, s);
    chk("relock_locked", pll_locked, passes(s, exp2));

    // locked windows with random tick drop-outs
    drop_pct = 8;
    for (int w = 0; w < 4; w++) begin
      e += int'(WIN);
      run_to(e);
      s = win_sum(e);
      chk("jit_meas", meas_count, s);
      chk("jit_locked", pll_locked, passes(s, exp2));
      if (!passes(s, exp2)) begin
        chk("jit_state_settle", state_o, 2);
        drop_pct = 0;
        e += int'(ST + WIN);
        run_to(e);
        s = win_sum(e);
        chk("jit_relock_meas", meas_count, s);
        chk("jit_relock", pll_locked, passes(s, exp2));
        drop_pct = 8;
      end
    end
    drop_pct = 0;

    // 5b. power down from LOCKED
    accept(1'b0, 4'h3, CNT_W'(1), n);
    chk("off_state", state_o, 0);
    chk("off_enb_cp", pll_enb_cp, 1);
    chk("off_enb_vco", pll_enb_vco, 1);
    chk("off_locked", pll_locked, 0);
    chk("off_b_hold", pll_b, 4'hA);

    // 3. no ticks -> three failing windows -> FAULT
    set_mode(0, 0, 0);
    rb = 4'($urandom_range(0, 15));
    accept(1'b1, rb, CNT_W'(8), n);
    chk("flt_b", pll_b, rb);
    run_to(n + 29);
    chk("flt_w1_meas", meas_count, win_sum(cyc));
    chk("flt_w1_state", state_o, 2);
    run_to(n + 53);
    chk("flt_w2_state", state_o, 2);
    run_to(n + 76);
    chk("flt_w3_pre", pll_fault, 0);
    run_to(n + 1 + int'(CP) + 3 * int'(ST + WIN));
    chk("flt_fault", pll_fault, 1);
    chk("flt_state", state_o, 5);
    chk("flt_enb_cp", pll_enb_cp, 1);
    chk("flt_enb_vco", pll_enb_vco, 1);
    chk("flt_ready", cfg_ready, 1);
    chk("flt_meas", meas_count, 0);

    // 6. restart from FAULT, then reset mid-MEASURE with a tick
    set_mode(2, int'($urandom_range(0, 1)), 0);
    accept(1'b1, 4'(rb + 4'd1), CNT_W'(8), n);
    chk("rf_fault_clr", pll_fault, 0);
    chk("rf_state", state_o, 1);
    run_to(n + 20);
    chk("rf_measure", state_o, 3);
    rst = 1'b1;
    fb_tick = 1'b1;
    hist[cyc + 1] = 1'b1;
    step();
    chk("mr_state", state_o, 0);
    chk("mr_enb_cp", pll_enb_cp, 1);
    chk("mr_enb_vco", pll_enb_vco, 1);
    chk("mr_b", pll_b, 0);
    chk("mr_meas", meas_count, 0);
    chk("mr_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_en = 1'b1;
    cfg_b = 4'hF;
    step();
    cfg_valid = 1'b0;
    chk("mr_accept_dropped", state_o, 0);
    chk("mr_accept_b", pll_b, 0);
    rst = 1'b0;
    run_to(cyc + 20);
    chk("post_rst_state", state_o, 0);
    chk("post_rst_meas", meas_count, 0);
    accept(1'b1, 4'h6, CNT_W'(8), n);
    run_to(n + 29);
    s = win_sum(cyc);
    chk("post_rst_lock_meas", meas_count, s);
    chk("post_rst_locked", pll_locked, passes(s, 8));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
